// File: rtl/result_fifo_reader_pkg.sv
// Shared types and constants for the host-side result FIFO read engine.
package result_fifo_reader_pkg;
  localparam int FIFO_WIDTH        = 32;
  localparam int MAX_RESULT_FIFOS  = 8;
  localparam int RESULT_FIFO_IDX_W = $clog2(MAX_RESULT_FIFOS);
  localparam int COUNT_W           = 16;
  localparam int HDR_RSVD_W        = FIFO_WIDTH - COUNT_W - RESULT_FIFO_IDX_W - 1;

  localparam logic RESULT_RESULTS_SEL = 1'b0;
  localparam logic PERF_RESULTS_SEL   = 1'b1;

  localparam logic [RESULT_FIFO_IDX_W-1:0] A_RESULTS_SEL    = 3'd0;
  localparam logic [RESULT_FIFO_IDX_W-1:0] C_RESULTS_SEL    = 3'd2;
  localparam logic [RESULT_FIFO_IDX_W-1:0] GEMM_RESULTS_SEL = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_STREAM, S_DRAIN} rd_state_e;

  typedef struct packed {
    logic [COUNT_W-1:0]           words;
    logic [HDR_RSVD_W-1:0]        rsvd;
    logic [RESULT_FIFO_IDX_W-1:0] fifo;
    logic                         sel;
  } rd_hdr_t;

  // An error header reuses the top bit of the words field and reports zero words.
  function automatic rd_hdr_t make_header(input logic err,
                                          input logic [COUNT_W-1:0] words,
                                          input logic [RESULT_FIFO_IDX_W-1:0] fifo,
                                          input logic sel);
    rd_hdr_t h;
    h.words = err ? {1'b1, {(COUNT_W-1){1'b0}}} : words;
    h.rsvd  = '0;
    h.fifo  = fifo;
    h.sel   = sel;
    return h;
  endfunction
endpackage

// File: rtl/result_fifo_reader_skid.sv
// Two-entry skid buffer; entry 0 is always the head presented downstream.
module rxtx_skid_buffer #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   count
);
  logic [W-1:0] e0, e1;
  logic [1:0]   cnt;
  logic         push, pop;

  assign push      = in_valid && (cnt != 2'd2);
  assign pop       = out_valid && out_ready;
  assign out_valid = (cnt != 2'd0);
  assign out_data  = e0;
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= in_data;
          else             e1 <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          e1  <= '0;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) e0 <= in_data;
          else begin
            e0 <= e1;
            e1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/result_fifo_reader.sv
// Read engine: header word then N words popped from a result/perf FIFO onto the tx stream.
module result_fifo_reader
  import result_fifo_reader_pkg::*;
#(
  parameter int TOTAL_RESULT_FIFOS = MAX_RESULT_FIFOS
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         req_valid,
  output logic                                         req_ready,
  input  logic                                         req_results_sel,
  input  logic [RESULT_FIFO_IDX_W-1:0]                 req_fifo,
  input  logic [COUNT_W-1:0]                           req_words,
  output logic [TOTAL_RESULT_FIFOS-1:0]                fifo_rdreq,
  input  logic [TOTAL_RESULT_FIFOS-1:0][FIFO_WIDTH-1:0] fifo_q,
  input  logic [TOTAL_RESULT_FIFOS-1:0]                fifo_empty,
  output logic                                         perf_rdreq,
  input  logic [FIFO_WIDTH-1:0]                        perf_q,
  input  logic                                         perf_empty,
  output logic                                         tx_valid,
  input  logic                                         tx_ready,
  output logic [FIFO_WIDTH-1:0]                        tx_data,
  output logic                                         tx_last
);
  localparam int BANK_W = (TOTAL_RESULT_FIFOS > 1) ? $clog2(TOTAL_RESULT_FIFOS) : 1;

  rd_state_e                    state, state_n;
  logic                         sel_l, err_l;
  logic [RESULT_FIFO_IDX_W-1:0] fifo_l;
  logic [COUNT_W-1:0]           words_l, issued;
  logic [COUNT_W:0]             issued_inc;
  logic                         pop, pop_d, last_d;
  logic                         req_err;
  logic [BANK_W-1:0]            bank;
  logic                         src_empty;
  logic [FIFO_WIDTH-1:0]        src_q;
  logic                         from_skid, deq, room, pop_window;
  logic                         skid_valid;
  logic [FIFO_WIDTH:0]          skid_data;
  logic [1:0]                   skid_cnt;
  logic [2:0]                   occ_ahead;
  rd_hdr_t                      hdr;

  assign req_err    = (req_results_sel == RESULT_RESULTS_SEL) &&
                      (int'(req_fifo) >= TOTAL_RESULT_FIFOS);
  assign bank       = fifo_l[BANK_W-1:0];
  assign src_empty  = sel_l ? perf_empty : fifo_empty[bank];
  assign src_q      = sel_l ? perf_q : fifo_q[bank];
  assign issued_inc = {1'b0, issued} + {{COUNT_W{1'b0}}, 1'b1};
  assign hdr        = make_header(err_l, words_l, fifo_l, sel_l);

  // Space check counts the pop already in flight and credits a word leaving this cycle.
  assign from_skid  = (state == S_STREAM) || (state == S_DRAIN);
  assign deq        = from_skid && skid_valid && tx_ready;
  assign occ_ahead  = {1'b0, skid_cnt} + {2'b0, pop_d};
  assign room       = occ_ahead < (3'd2 + {2'b0, deq});
  // Popping while the header is being accepted hides one cycle of FIFO latency.
  assign pop_window = (state == S_STREAM) || ((state == S_HEADER) && tx_ready);
  assign pop        = pop_window && (issued < words_l) && !src_empty && room;

  always_comb begin
    fifo_rdreq = '0;
    for (int i = 0; i < TOTAL_RESULT_FIFOS; i++)
      fifo_rdreq[i] = pop && (sel_l == RESULT_RESULTS_SEL) && (int'(fifo_l) == i);
  end
  assign perf_rdreq = pop && (sel_l == PERF_RESULTS_SEL);

  rxtx_skid_buffer #(.W(FIFO_WIDTH + 1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (pop_d),
    .in_data   ({last_d, src_q}),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .out_ready (from_skid && tx_ready),
    .count     (skid_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      sel_l   <= 1'b0;
      err_l   <= 1'b0;
      fifo_l  <= '0;
      words_l <= '0;
      issued  <= '0;
      pop_d   <= 1'b0;
      last_d  <= 1'b0;
    end else begin
      state  <= state_n;
      pop_d  <= pop;
      last_d <= pop && (issued_inc == {1'b0, words_l});
      if (state == S_IDLE && req_valid) begin
        sel_l   <= req_results_sel;
        err_l   <= req_err;
        fifo_l  <= req_results_sel ? '0 : req_fifo;
        words_l <= req_err ? '0 : req_words;
        issued  <= '0;
      end else if (pop) begin
        issued <= issued_inc[COUNT_W-1:0];
      end
    end
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_last   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = S_HEADER;
      end
      S_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = hdr;
        tx_last  = (words_l == '0);
        if (tx_ready) state_n = (words_l == '0) ? S_IDLE : S_STREAM;
      end
      S_STREAM, S_DRAIN: begin
        tx_valid = skid_valid;
        if (skid_valid) {tx_last, tx_data} = skid_data;
        if (state == S_STREAM && issued == words_l) state_n = S_DRAIN;
        if (state == S_DRAIN && skid_valid && tx_ready && skid_data[FIFO_WIDTH])
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_result_fifo_reader.sv
// Bench for result_fifo_reader: queue-based FIFO models, stream scoreboard, scenario tasks.
module tb_result_fifo_reader;
  import result_fifo_reader_pkg::*;
  localparam int NF = 4;

  logic clk, reset;
  logic req_valid, req_ready, req_results_sel;
  logic [2:0] req_fifo;
  logic [15:0] req_words;
  logic [NF-1:0] fifo_rdreq, fifo_empty;
  logic [NF-1:0][31:0] fifo_q;
  logic perf_rdreq, perf_empty;
  logic [31:0] perf_q;
  logic tx_valid, tx_ready, tx_last;
  logic [31:0] tx_data;

  result_fifo_reader #(.TOTAL_RESULT_FIFOS(NF)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_results_sel(req_results_sel), .req_fifo(req_fifo), .req_words(req_words),
    .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .perf_rdreq(perf_rdreq), .perf_q(perf_q), .perf_empty(perf_empty),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last));

  initial clk = 0;
  always #5 clk = ~clk;

  logic [31:0] fq [NF+1][$];  // entry NF is the perf FIFO
  int pops [NF+1];
  int pop_empty_viol, onehot_viol, stall_viol;
  logic [32:0] cap_q[$], exp_q[$];
  logic prev_stall;
  logic [32:0] prev_word;
  int total, bad;

  // FIFO models: 1-cycle read latency, empty flag refreshed away from the active edge.
  always @(posedge clk) begin
    for (int i = 0; i < NF; i++) if (fifo_rdreq[i] === 1'b1) begin
      if (fq[i].size() == 0) pop_empty_viol <= pop_empty_viol + 1;
      else fifo_q[i] <= fq[i].pop_front();
      pops[i] <= pops[i] + 1;
    end
    if (perf_rdreq === 1'b1) begin
      if (fq[NF].size() == 0) pop_empty_viol <= pop_empty_viol + 1;
      else perf_q <= fq[NF].pop_front();
      pops[NF] <= pops[NF] + 1;
    end
    if (int'($countones(fifo_rdreq)) + int'(perf_rdreq === 1'b1) > 1) onehot_viol <= onehot_viol + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NF; i++) fifo_empty[i] <= (fq[i].size() == 0);
    perf_empty <= (fq[NF].size() == 0);
    if (!reset && tx_valid && tx_ready) cap_q.push_back({tx_last, tx_data});
    if (!reset && prev_stall && (!tx_valid || {tx_last, tx_data} !== prev_word)) stall_viol <= stall_viol + 1;
    prev_stall <= !reset && tx_valid && !tx_ready;
    prev_word  <= {tx_last, tx_data};
  end

  // Reference: header from the field rules, then the payload in push order.
  function automatic logic [31:0] ref_hdr(input logic sel, input int f, input int w);
    if (!sel && f >= NF) return 32'h8000_0000 | 32'(f * 2);
    return 32'(w * 65536 + (sel ? 0 : f * 2) + (sel ? 1 : 0));
  endfunction

  task automatic add_exp(input logic sel, input int f, input int w, input logic [31:0] vals[$]);
    bit err = !sel && f >= NF;
    exp_q.push_back({(w == 0) || err, ref_hdr(sel, f, w)});
    if (!err) for (int i = 0; i < w; i++) exp_q.push_back({i == w - 1, vals[i]});
  endtask

  task automatic clear_all();
    cap_q.delete(); exp_q.delete();
    for (int i = 0; i <= NF; i++) pops[i] = 0;
  endtask

  task automatic issue_req(input logic sel, input int f, input int w);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_wait: got %b want 1", req_ready); end
    req_results_sel = sel; req_fifo = 3'(f); req_words = 16'(w); req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic wait_caps(input int n);
    for (int k = 0; k < 500 && cap_q.size() < n; k++) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1; req_valid = 0; tx_ready = 1; req_results_sel = 0; req_fifo = 0; req_words = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    total++; if ({tx_valid, tx_last} !== 2'b00) begin bad++; $display("FAIL reset_tx_flags: got %b want 00", {tx_valid, tx_last}); end
    total++; if (tx_data !== 32'h0) begin bad++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
    total++; if ({fifo_rdreq, perf_rdreq} !== '0) begin bad++; $display("FAIL reset_rdreq: got %b want 0", {fifo_rdreq, perf_rdreq}); end
    reset = 0;
  endtask

  task automatic test_basic();
    logic [31:0] vals[$] = '{32'h10, 32'h11, 32'h12, 32'h13};
    clear_all();
    foreach (vals[i]) fq[GEMM_RESULTS_SEL].push_back(vals[i]);
    add_exp(0, 3, 4, vals);
    repeat (2) @(posedge clk);
    issue_req(RESULT_RESULTS_SEL, 3, 4);
    total++; if (!(tx_valid === 1'b1 && tx_data === 32'h00040006)) begin bad++; $display("FAIL basic_hdr_latency: got v=%b %h want v=1 00040006", tx_valid, tx_data); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", req_ready); end
    repeat (6) @(posedge clk);
    #1;
    total++; if (cap_q.size() != 5) begin bad++; $display("FAIL basic_throughput: got %0d words want 5", cap_q.size()); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back: got %b want 1", req_ready); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_word%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
    end
    total++; if (pops[3] != 4 || pops[0] + pops[1] + pops[2] + pops[NF] != 0) begin bad++; $display("FAIL basic_pops: got %0d on fifo3 %0d elsewhere want 4/0", pops[3], pops[0] + pops[1] + pops[2] + pops[NF]); end
  endtask

  task automatic test_perf_zero();
    logic [31:0] vals[$];
    clear_all();
    fq[NF].push_back($urandom);
    add_exp(1, 0, 0, vals);
    issue_req(PERF_RESULTS_SEL, $urandom_range(0, 7), 0);
    wait_caps(1); repeat (3) @(posedge clk);
    total++; if (cap_q.size() != 1) begin bad++; $display("FAIL perf0_count: got %0d want 1", cap_q.size()); end
    total++; if (cap_q.size() < 1 || cap_q[0] !== 33'h1_0000_0001) begin bad++; $display("FAIL perf0_hdr: got %h want 100000001", cap_q.size() ? cap_q[0] : 33'h0); end
    total++; if (pops[NF] != 0) begin bad++; $display("FAIL perf0_pops: got %0d want 0", pops[NF]); end
    fq[NF].delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] vals[$];
    int f = $urandom_range(0, NF - 1), pushed = 0;
    clear_all();
    for (int i = 0; i < 8; i++) vals.push_back($urandom);
    add_exp(0, f, 8, vals);
    issue_req(RESULT_RESULTS_SEL, f, 8);
    for (int c = 0; c < 400 && cap_q.size() < 9; c++) begin
      @(posedge clk); #1;
      tx_ready = ~tx_ready;
      if (c % 3 == 0 && pushed < 8) begin fq[f].push_back(vals[pushed]); pushed++; end
    end
    tx_ready = 1; repeat (3) @(posedge clk);
    total++; if (cap_q.size() != 9) begin bad++; $display("FAIL bp_count: got %0d want 9", cap_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
    end
    total++; if (pops[f] != 8) begin bad++; $display("FAIL bp_pops: got %0d want 8", pops[f]); end
    total++; if (pop_empty_viol != 0) begin bad++; $display("FAIL bp_pop_empty: got %0d want 0", pop_empty_viol); end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL bp_stall_hold: got %0d want 0", stall_viol); end
  endtask

  task automatic test_invalid();
    logic [31:0] vals[$];
    int f = (NF < 7) ? 7 : NF;
    clear_all();
    fq[f % NF].push_back($urandom);
    add_exp(0, f, 5, vals);
    issue_req(RESULT_RESULTS_SEL, f, $urandom_range(1, 100));
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL inv_ready_back: got %b want 1", req_ready); end
    repeat (3) @(posedge clk);
    total++; if (cap_q.size() != 1 || cap_q[0] !== exp_q[0]) begin bad++; $display("FAIL inv_hdr: got n=%0d %h want n=1 %h", cap_q.size(), cap_q.size() ? cap_q[0] : 33'h0, exp_q[0]); end
    total++; if (pops[0] + pops[1] + pops[2] + pops[3] + pops[NF] != 0) begin bad++; $display("FAIL inv_pops: got %0d want 0", pops[0] + pops[1] + pops[2] + pops[3] + pops[NF]); end
    fq[f % NF].delete();
  endtask

  task automatic test_reset_mid();
    logic [31:0] vals[$];
    int f = $urandom_range(0, NF - 1);
    clear_all();
    for (int i = 0; i < 5; i++) fq[f].push_back($urandom);
    issue_req(RESULT_RESULTS_SEL, f, 5);
    wait_caps(3);
    #1 reset = 1;
    @(posedge clk); #1;
    total++; if ({tx_valid, tx_last, req_ready} !== 3'b001) begin bad++; $display("FAIL midrst_flags: got %b want 001", {tx_valid, tx_last, req_ready}); end
    total++; if (tx_data !== 32'h0 || {fifo_rdreq, perf_rdreq} !== '0) begin bad++; $display("FAIL midrst_data: got %h/%b want 0/0", tx_data, {fifo_rdreq, perf_rdreq}); end
    reset = 0;
    for (int i = 0; i <= NF; i++) fq[i].delete();
    repeat (2) @(posedge clk);
    clear_all();
    vals.push_back($urandom);
    fq[f].push_back(vals[0]);
    add_exp(0, f, 1, vals);
    issue_req(RESULT_RESULTS_SEL, f, 1);
    wait_caps(2); repeat (2) @(posedge clk);
    total++; if (cap_q.size() != 2) begin bad++; $display("FAIL midrst_count: got %0d want 2", cap_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_word%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[$], vc[$];
    int n1 = $urandom_range(1, 6), n2 = $urandom_range(1, 6), k = 0;
    clear_all();
    for (int i = 0; i < n1; i++) begin va.push_back($urandom); fq[A_RESULTS_SEL].push_back(va[i]); end
    for (int i = 0; i < n2; i++) begin vc.push_back($urandom); fq[C_RESULTS_SEL].push_back(vc[i]); end
    add_exp(0, 0, n1, va);
    add_exp(0, 2, n2, vc);
    issue_req(RESULT_RESULTS_SEL, A_RESULTS_SEL, n1);
    @(negedge clk);
    while (!req_ready && k < 200) begin @(negedge clk); k++; end
    req_fifo = C_RESULTS_SEL; req_words = 16'(n2); req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    total++; if (!(tx_valid === 1'b1 && tx_data === ref_hdr(0, 2, n2))) begin bad++; $display("FAIL b2b_hdr2: got v=%b %h want v=1 %h", tx_valid, tx_data, ref_hdr(0, 2, n2)); end
    wait_caps(n1 + n2 + 2); repeat (2) @(posedge clk);
    total++; if (cap_q.size() != n1 + n2 + 2) begin bad++; $display("FAIL b2b_count: got %0d want %0d", cap_q.size(), n1 + n2 + 2); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_word%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
    end
    total++; if (onehot_viol != 0) begin bad++; $display("FAIL b2b_onehot: got %0d want 0", onehot_viol); end
  endtask

  task automatic test_random();
    clear_all();
    for (int it = 0; it < 6; it++) begin
      logic [31:0] vals[$];
      logic sel = 1'($urandom_range(0, 1));
      int f = $urandom_range(0, 7), w = $urandom_range(0, 6);
      int src = sel ? NF : f;
      for (int i = 0; i < w; i++) vals.push_back($urandom);
      if (sel || f < NF) foreach (vals[i]) fq[src].push_back(vals[i]);
      add_exp(sel, f, w, vals);
      issue_req(sel, f, w);
      for (int c = 0; c < 300 && cap_q.size() < exp_q.size(); c++) begin
        @(posedge clk); #1 tx_ready = 1'($urandom);
      end
      tx_ready = 1;
    end
    repeat (4) @(posedge clk);
    total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++; if (cap_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_word%0d: got %h want %h", i, cap_q[i], exp_q[i]); end
    end
    total++; if (pop_empty_viol + onehot_viol + stall_viol != 0) begin bad++; $display("FAIL rand_protocol: got %0d violations want 0", pop_empty_viol + onehot_viol + stall_viol); end
  endtask

  initial begin
    total = 0; bad = 0; pop_empty_viol = 0; onehot_viol = 0; stall_viol = 0;
    fifo_q = '0; perf_q = '0;
    test_reset();
    test_basic();
    test_perf_zero();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
